// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding selects,
// load-use / cache-miss / branch-flush sequencing, and stall/bubble counters.
module hazard_ctrl_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_rs2,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic             fwd_mem_sel,
    output logic             ctrl_sel,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // forwardingmux1_sel_t
    localparam logic [1:0] FWD_ID_EX  = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    // forwardingmux2_sel_t
    localparam logic FWDM_MEM = 1'b0;
    localparam logic FWDM_WB  = 1'b1;
    // controlmux_sel_t
    localparam logic CTRL_ZERO = 1'b0;
    localparam logic CTRL_NORM = 1'b1;

    typedef enum logic [1:0] {RUN, DWAIT, IWAIT} state_t;

    state_t state;
    logic   flush_pend;
    logic   d_miss, d_freeze, flush_go, i_stall, load_use, bubble_ins;

    function automatic logic [1:0] fwd_pick(input logic [REG_W-1:0] r,
                                            input logic [REG_W-1:0] mrd, input logic mrw,
                                            input logic [REG_W-1:0] wrd, input logic wrw);
        if (r != '0 && mrw && mrd == r)      return FWD_EX_MEM;
        else if (r != '0 && wrw && wrd == r) return FWD_MEM_WB;
        else                                 return FWD_ID_EX;
    endfunction

    always_comb begin
        fwd1_sel    = fwd_pick(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd2_sel    = fwd_pick(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_mem_sel = (wb_regwrite && wb_rd == mem_rs2 && mem_rs2 != '0) ? FWDM_WB : FWDM_MEM;
    end

    // In DWAIT the freeze lasts until the response arrives; elsewhere a fresh
    // unanswered request freezes the pipe in its detect cycle.
    assign d_miss   = dmem_req && !dmem_resp;
    assign d_freeze = !rst && ((state == DWAIT) ? !dmem_resp : d_miss);
    // Redirects wait until the D-miss has fully retired back to RUN.
    assign flush_go = !rst && !d_freeze && (state != DWAIT) && (ex_br_taken || flush_pend);
    assign i_stall  = !rst && !imem_resp;
    assign load_use = !rst && ex_is_load && ex_rd != '0 &&
                      ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    assign bubble_ins = !d_freeze && (flush_go || i_stall || load_use);

    always_comb begin
        pc_load     = 1'b1;
        if_id_load  = 1'b1;
        id_ex_load  = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
        if_id_flush = 1'b0;
        ctrl_sel    = CTRL_NORM;
        if (d_freeze) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
        end else if (flush_go) begin
            if_id_flush = 1'b1;
            ctrl_sel    = CTRL_ZERO;
        end else if (i_stall || load_use) begin
            pc_load    = 1'b0;
            if_id_load = 1'b0;
            ctrl_sel   = CTRL_ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_pend <= 1'b0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            case (state)
                RUN:     if (d_miss) state <= DWAIT;
                         else if (!imem_resp) state <= IWAIT;
                DWAIT:   if (dmem_resp) state <= RUN;
                IWAIT:   if (d_miss) state <= DWAIT;
                         else if (imem_resp) state <= RUN;
                default: state <= RUN;
            endcase
            flush_pend <= (flush_pend || ex_br_taken) && !flush_go;
            if (d_freeze)   stall_cnt  <= stall_cnt + 1'b1;
            if (bubble_ins) bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule
